fetch_unit: RTL

Instruction fetch front end of the milestone CPU. It produces the instruction stream that the control decoder consumes, and it consumes the redirects raised by branch/jump resolution (br_sel/jump_sel path).
- Owns the PC and issues pipelined reads to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions in a small queue.
- Presents instructions to decode with a valid/ready handshake.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/inst_queue.sv | 77 +++++++
 rtl/fetch_unit.sv | 115 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction fetch front end.
//   XLEN             - datapath width
//   DEFAULT_RESET_PC - default PC after reset
//   NOP_INST         - instruction presented to decode while nothing is valid
//   fetch_entry_t    - one buffered instruction with the PC it was fetched from
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/inst_queue.sv
// inst_queue: synchronous FIFO of fetch_entry_t between memory responses and decode.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   push        - write push_entry (ignored when full)
//   push_entry  - entry to write
//   pop         - drop the head entry (ignored when empty)
//   flush       - empty the queue; wins over push and pop
//   head        - current head entry (contents undefined when empty)
//   full, empty - occupancy flags
//   count       - number of entries held
module inst_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  fetch_entry_t                   push_entry,
  input  logic                           pop,
  input  logic                           flush,
  output fetch_entry_t                   head,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_entry_t   mem_q [DEPTH];
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q,  count_d;
  logic           do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end. Owns the PC, issues pipelined reads
// over a req/gnt/rvalid handshake, buffers responses and hands them to decode.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   imem_req/imem_addr    - fetch request and word-aligned address
//   imem_gnt              - request accepted this cycle
//   imem_rvalid/rdata     - in-order read response
//   redirect/redirect_pc  - taken branch / jump from execute, new PC
//   inst_valid/inst/inst_pc/inst_ready - valid/ready stream to decode
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned CW = $clog2(QDEPTH + 1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  // PC of the next response that will be kept; stands in for a per-grant tag FIFO
  // because responses return in order.
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;

  logic            grant, resp_keep;
  logic [CW:0]     in_flight;
  logic [XLEN-1:0] target_pc;
  logic            q_push, q_pop, q_full, q_empty;
  logic [CW-1:0]   q_count;
  fetch_entry_t    q_entry, q_head;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign target_pc = {redirect_pc[31:2], 2'b00};

  // Discarded reads still hold credit until their response returns.
  assign in_flight = {1'b0, outstanding_q} + {1'b0, q_count};
  assign imem_req  = !rst && (in_flight < (CW+1)'(QDEPTH));
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req && imem_gnt;
  assign resp_keep = imem_rvalid && (discard_q == '0);

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid);
    discard_d     = discard_q;
    if (grant)     fetch_pc_d = fetch_pc_q + 32'd4;
    if (resp_keep) resp_pc_d  = resp_pc_q + 32'd4;
    if (imem_rvalid && (discard_q != '0)) discard_d = discard_q - CW'(1);
    // Everything still in flight after this cycle belongs to the old path,
    // including a read granted in the redirect cycle itself.
    if (redirect) begin
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      discard_d  = outstanding_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  assign q_entry = '{inst: imem_rdata, pc: resp_pc_q};
  assign q_push  = resp_keep && !redirect;
  assign q_pop   = inst_valid && inst_ready && !redirect;

  inst_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (q_push),
    .push_entry (q_entry),
    .pop        (q_pop),
    .flush      (redirect),
    .head       (q_head),
    .full       (q_full),
    .empty      (q_empty),
    .count      (q_count)
  );

  assign inst_valid = !q_empty;
  assign inst       = q_empty ? NOP_INST : q_head.inst;
  assign inst_pc    = q_empty ? RESET_PC : q_head.pc;

  // Credit accounting guarantees a response always has a free slot.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(q_push && q_full));

endmodule
